// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a VGA h_sync/v_sync pair, checks line/frame geometry and reports lock.
// Define VGA_DEC_ERRCNT_EN to add an 8-bit saturating err_count output.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_LEN   = 96,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_LEN   = 2,
  parameter int unsigned V_TOTAL      = 521,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err
`ifdef VGA_DEC_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int unsigned CW = 10;
  localparam int unsigned GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << CW) - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'((1 << CW) - 2);

  typedef enum logic [1:0] {SEARCH, HLOCK, VLOCK, LOCKED} state_t;

  state_t        state_q;
  logic          hs_q, vs_q;
  logic          h_seen_q, v_seen_q;
  logic          h_err_q, v_err_q, locked_q, good_line_q;
  logic [GW-1:0] good_frames_q;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] line_len_q, line_len_d, hs_len_q, hs_len_d;
  logic [CW-1:0] frame_len_q, frame_len_d, vs_len_q, vs_len_d;
  logic          h_fall, h_rise, v_fall, v_rise, x_wrap;
  logic          line_ok_c, h_bad_c, v_bad_c, any_err_c;

  // Edge detection, coordinate tracking and geometry measurement
  always_comb begin
    h_fall = hs_q & ~h_sync;
    h_rise = ~hs_q & h_sync;
    v_fall = vs_q & ~v_sync;
    v_rise = ~vs_q & v_sync;
    x_wrap = ~h_fall & (x_q == CW'(H_TOTAL - 1));

    x_d = x_q + 1'b1;
    if (h_fall)      x_d = CW'(H_SYNC_START);
    else if (x_wrap) x_d = '0;

    y_d = y_q;
    if (v_fall)      y_d = CW'(V_SYNC_START);
    else if (x_wrap) y_d = (y_q == CW'(V_TOTAL - 1)) ? '0 : y_q + 1'b1;

    line_len_d = line_len_q;
    if (h_fall)                     line_len_d = CW'(1);
    else if (line_len_q != CNT_MAX) line_len_d = line_len_q + 1'b1;

    hs_len_d = hs_len_q;
    if (h_fall)                             hs_len_d = CW'(1);
    else if (~h_sync && hs_len_q != CNT_MAX) hs_len_d = hs_len_q + 1'b1;

    // A wrap coincident with v_fall belongs to the frame that is starting
    frame_len_d = frame_len_q;
    if (v_fall)                             frame_len_d = CW'(x_wrap);
    else if (x_wrap && frame_len_q != CNT_MAX) frame_len_d = frame_len_q + 1'b1;

    vs_len_d = vs_len_q;
    if (v_fall)                                     vs_len_d = CW'(x_wrap);
    else if (~v_sync && x_wrap && vs_len_q != CNT_MAX) vs_len_d = vs_len_q + 1'b1;

    line_ok_c = h_fall & h_seen_q & (line_len_q == CW'(H_TOTAL));
    // A saturated line length was already reported when it saturated
    h_bad_c   = (h_fall & h_seen_q & (line_len_q != CNT_MAX) & (line_len_q != CW'(H_TOTAL)))
              | (h_rise & (hs_len_q != CW'(H_SYNC_LEN)))
              | (h_seen_q & ~h_fall & (line_len_q == CNT_PRE));
    v_bad_c   = (v_fall & v_seen_q & (frame_len_q != CW'(V_TOTAL)))
              | (v_rise & (vs_len_q != CW'(V_SYNC_LEN)));
    any_err_c = h_err_q | v_err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      locked_q      <= 1'b0;
      good_line_q   <= 1'b0;
      good_frames_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_len_q    <= '0;
      hs_len_q      <= '0;
      frame_len_q   <= '0;
      vs_len_q      <= '0;
    end else begin
      hs_q        <= h_sync;
      vs_q        <= v_sync;
      h_seen_q    <= h_seen_q | h_fall;
      v_seen_q    <= v_seen_q | v_fall;
      h_err_q     <= h_bad_c;
      v_err_q     <= v_bad_c;
      x_q         <= x_d;
      y_q         <= y_d;
      line_len_q  <= line_len_d;
      hs_len_q    <= hs_len_d;
      frame_len_q <= frame_len_d;
      vs_len_q    <= vs_len_d;
      case (state_q)
        SEARCH: begin
          if (h_fall) begin
            state_q     <= HLOCK;
            good_line_q <= 1'b0;
          end
        end
        HLOCK: begin
          if (any_err_c) begin
            state_q <= SEARCH;
          end else if (v_fall && good_line_q) begin
            state_q       <= VLOCK;
            good_frames_q <= '0;
          end else if (line_ok_c) begin
            good_line_q <= 1'b1;
          end
        end
        VLOCK: begin
          if (any_err_c) begin
            state_q <= SEARCH;
          end else if (v_fall && !v_bad_c && !h_bad_c) begin
            if (32'(good_frames_q) + 32'd1 >= LOCK_FRAMES) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end else begin
              good_frames_q <= good_frames_q + 1'b1;
            end
          end
        end
        default: begin
          if (any_err_c) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // One count per cycle with any error pulse, holding at full scale
  always_ff @(posedge clock) begin
    if (reset)                            err_cnt_q <= '0;
    else if (any_err_c && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_count = err_cnt_q;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign active      = locked_q & (x_q < CW'(H_ACTIVE)) & (y_q < CW'(V_ACTIVE));
  assign frame_start = locked_q & (x_q == '0) & (y_q == '0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 16x10 timing generator.
module tb_vga_sync_decoder;

  localparam int HA = 8, HSS = 10, HSL = 3, HT = 16;
  localparam int VA = 6, VSS = 7, VSL = 2, VT = 10, LF = 2;

  logic       clock = 1'b0;
  logic       reset, h_sync, v_sync;
  logic [9:0] x, y;
  logic       active, frame_start, locked, h_err, v_err;
`ifdef VGA_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int tests = 0, fails = 0;
  int gx, gy, line_ht, line_hsl, def_hsl;
  bit hold_h, chk_xy, chk_act;
  int n_herr, n_verr, n_fs, n_act, xy_bad, act_bad, base;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clock(clock), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .x(x), .y(y), .active(active), .frame_start(frame_start),
    .locked(locked), .h_err(h_err), .v_err(v_err)
`ifdef VGA_DEC_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel clock of the reference generator; outputs sampled 1 time unit after the edge
  task automatic tick();
    logic hs, vs;
    hs = hold_h ? 1'b1 : !(gx >= HSS - 1 && gx < HSS - 1 + line_hsl);
    vs = !((gy == VSS && gx >= HSS - 1) || (gy > VSS && gy < VSS + VSL) ||
           (gy == VSS + VSL && gx < HSS - 1));
    h_sync = hs;
    v_sync = vs;
    @(posedge clock);
    #1;
    if (gx == line_ht - 1) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
      line_ht = HT;
      line_hsl = def_hsl;
    end else begin
      gx++;
    end
    if (h_err) n_herr++;
    if (v_err) n_verr++;
    if (chk_xy && (x !== 10'(gx) || y !== 10'(gy))) xy_bad++;
    if (chk_act) begin
      if (frame_start !== (gx == 0 && gy == 0)) act_bad++;
      if (active !== (gx < HA && gy < VA)) act_bad++;
      if (frame_start) n_fs++;
      if (active) n_act++;
    end
  endtask

  task automatic run_to(input int fy, input int fx);
    int n;
    n = 0;
    while (!(gx == fx && gy == fy) && n < 2000) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; h_sync = 1'b1; v_sync = 1'b1;
    gx = 0; gy = 0; line_ht = HT; line_hsl = HSL; def_hsl = HSL;
    hold_h = 0; chk_xy = 0; chk_act = 0;
    n_herr = 0; n_verr = 0; n_fs = 0; n_act = 0; xy_bad = 0; act_bad = 0; base = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_active", 32'(active), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_h_err", 32'(h_err), 0);
    check("rst_v_err", 32'(v_err), 0);
    reset = 1'b0;
    chk_xy = 1;

    // Acquisition: third v_fall lands on cycle 2*160 + 7*16 + 9 = 441
    repeat (441) tick();
    check("pre_lock", 32'(locked), 0);
    tick();
    check("lock_rise", 32'(locked), 1);
    check("x_sync_load", 32'(x), HSS);
    check("y_sync_load", 32'(y), VSS);
    check("acq_h_err_cnt", 32'(n_herr), 0);
    check("acq_v_err_cnt", 32'(n_verr), 0);

    // One locked frame: single frame_start, 8x6 active pixels
    run_to(VT - 1, HT - 1);
    chk_act = 1;
    repeat (HT * VT) tick();
    chk_act = 0;
    check("frame_start_cnt", 32'(n_fs), 1);
    check("active_cnt", 32'(n_act), HA * VA);
    check("active_fs_placement", 32'(act_bad), 0);
    check("xy_track_locked", 32'(xy_bad), 0);

    // Line 8 stretched to HT+1 clocks
    run_to(VSS, HT - 1);
    line_ht = HT + 1;
    chk_xy = 0;
    run_to(VSS + 2, HSS - 1);
    check("long_line_h_err", 32'(h_err), 1);
    check("long_line_locked_hold", 32'(locked), 1);
    tick();
    check("long_line_h_err_single", 32'(h_err), 0);
    check("long_line_unlock", 32'(locked), 0);
    chk_xy = 1;
    run_to(VSS, HSS - 1);
    check("relock_v1", 32'(locked), 0);
    run_to(VSS, HSS - 1);
    check("relock_v2", 32'(locked), 0);
    run_to(VSS, HSS - 1);
    check("relock_v3", 32'(locked), 1);
    check("long_line_h_err_cnt", 32'(n_herr), 1);
    check("long_line_v_err_cnt", 32'(n_verr), 0);

    // h_sync pulse one clock short on line 2
    run_to(1, HT - 1);
    line_hsl = HSL - 1;
    run_to(2, HSS + HSL - 2);
    check("short_hs_h_err", 32'(h_err), 1);
    tick();
    check("short_hs_unlock", 32'(locked), 0);
    check("short_hs_h_err_cnt", 32'(n_herr), 2);

    // h_sync stuck high past line_len saturation
    base = n_herr;
    xy_bad = 0;
    hold_h = 1;
    repeat (1100) tick();
    check("hold_single_h_err", 32'(n_herr - base), 1);
    check("hold_locked", 32'(locked), 0);
    check("hold_x_wraps", 32'(xy_bad), 0);
    hold_h = 0;
    repeat (3 * HT) tick();
    check("resume_no_extra_err", 32'(n_herr - base), 1);
    run_to(VSS, HSS - 1);
    run_to(VSS, HSS - 1);
    check("hold_relock_pending", 32'(locked), 0);
    run_to(VSS, HSS - 1);
    check("hold_relock", 32'(locked), 1);
    check("v_err_total", 32'(n_verr), 0);

    // Reset mid-frame forces full reacquisition
    repeat (37) tick();
    chk_xy = 0;
    reset = 1'b1;
    tick();
    check("midrst_x", 32'(x), 0);
    check("midrst_y", 32'(y), 0);
    check("midrst_locked", 32'(locked), 0);
    check("midrst_active", 32'(active), 0);
    check("midrst_frame_start", 32'(frame_start), 0);
    reset = 1'b0;
    gx = 0; gy = 0; line_ht = HT; line_hsl = HSL;
    chk_xy = 1; xy_bad = 0;
    repeat (441) tick();
    check("reacq_pre_lock", 32'(locked), 0);
    tick();
    check("reacq_lock", 32'(locked), 1);
    check("reacq_xy", 32'(xy_bad), 0);

`ifdef VGA_DEC_ERRCNT_EN
    run_to(VSS, HT - 1);
    def_hsl = HSL - 1;
    line_hsl = HSL - 1;
    repeat (300 * HT) tick();
    def_hsl = HSL;
    repeat (HT) tick();
    check("err_count_sat", 32'(err_count), 255);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("err_count_rst", 32'(err_count), 0);
    check("err_count_rst_x", 32'(x), 0);
    check("err_count_rst_y", 32'(y), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
